// File: rtl/intr_pkg.sv
// Shared constants, FSM state type and priority helper for the interrupt arbiter.
package intr_pkg;

  localparam logic [7:0] INTR_MASK_ID = 8'h50;
  localparam logic [7:0] INTR_ACK_ID  = 8'h51;
  localparam logic [7:0] INTR_STAT_ID = 8'h52;
  localparam logic [7:0] INTR_VEC_ID  = 8'h53;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2
  } intr_state_e;

  // Lowest set bit wins; index 0 is highest priority.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/intr_arbiter_if.sv
// MCU I/O bus as seen by the interrupt arbiter: port write/read plus interrupt line.
interface intr_arbiter_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_DATA;
  logic       INTERRUPT;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB,
                  input  IN_DATA, input  INTERRUPT);
  modport slave  (input  PORT_ID, input  OUT_PORT, input  IO_STRB,
                  output IN_DATA, output INTERRUPT);
endinterface

// File: rtl/intr_edge_sync.sv
// One-bit 2-flop synchronizer with a rising-edge pulse; edges are ignored until
// the pipeline has been refilled after reset so lines high at release do not fire.
module intr_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse_c
);

  logic       sync1, sync2, sync3;
  logic [2:0] primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      primed <= 3'b000;
    end else begin
      sync1  <= d;
      sync2  <= sync1;
      sync3  <= sync2;
      primed <= {primed[1:0], 1'b1};
    end
  end

  assign pulse_c = primed[2] & sync2 & ~sync3;

endmodule

// File: rtl/intr_arbiter.sv
// Prioritised interrupt arbiter for an 8-bit MCU I/O bus.
// Optional macro INTR_TIMEOUT_EN: WAIT_ACK gives up after TIMEOUT_CYC cycles.
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  intr_arbiter_if.slave      bus
);

  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  if (NUM_SRC < 1 || NUM_SRC > 8 || HOLD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_cfg_err
    $error("intr_arbiter: unsupported parameter set");
  end

  logic [NUM_SRC-1:0] edge_pulse, pending, pending_nxt, mask, ack_clr, active;
  logic               mask_wr, ack_wr;
  intr_state_e        state, state_nxt;
  logic [2:0]         vector, vector_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic               interrupt_q, interrupt_nxt;
  logic [7:0]         in_data_c;

  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_sync
    intr_edge_sync u_sync (
      .clk     (CLK),
      .rst_n   (RST_N),
      .d       (IRQ_IN[i]),
      .pulse_c (edge_pulse[i])
    );
  end

  assign mask_wr     = bus.IO_STRB && (bus.PORT_ID == INTR_MASK_ID);
  assign ack_wr      = bus.IO_STRB && (bus.PORT_ID == INTR_ACK_ID);
  assign ack_clr     = ack_wr ? bus.OUT_PORT[NUM_SRC-1:0] : '0;
  // A new edge in the same cycle as its clear keeps the bit set.
  assign pending_nxt = (pending & ~ack_clr) | edge_pulse;
  assign active      = pending & mask;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= pending_nxt;
      if (mask_wr) mask <= bus.OUT_PORT[NUM_SRC-1:0];
    end
  end

`ifdef INTR_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) to_cnt <= '0;
    else        to_cnt <= to_cnt_nxt;
  end
`endif

  // Registered FSM state, vector, hold counter and interrupt line.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      vector      <= 3'd0;
      hold_cnt    <= '0;
      interrupt_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      vector      <= vector_nxt;
      hold_cnt    <= hold_cnt_nxt;
      interrupt_q <= interrupt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    vector_nxt    = vector;
    hold_cnt_nxt  = hold_cnt;
    interrupt_nxt = 1'b0;
`ifdef INTR_TIMEOUT_EN
    to_cnt_nxt    = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (|active) begin
          state_nxt     = ASSERT;
          vector_nxt    = lowest_idx(8'(active));
          hold_cnt_nxt  = '0;
          interrupt_nxt = 1'b1;
        end
      end
      ASSERT: begin
        if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
          state_nxt  = WAIT_ACK;
`ifdef INTR_TIMEOUT_EN
          to_cnt_nxt = '0;
`endif
        end else begin
          hold_cnt_nxt  = hold_cnt + HOLD_W'(1);
          interrupt_nxt = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (ack_wr) begin
          state_nxt = IDLE;
        end
`ifdef INTR_TIMEOUT_EN
        else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Side-effect-free combinational register reads.
  always_comb begin
    in_data_c = 8'h00;
    case (bus.PORT_ID)
      INTR_MASK_ID: in_data_c = 8'(mask);
      INTR_STAT_ID: in_data_c = 8'(active);
      INTR_VEC_ID:  in_data_c = {5'b00000, vector};
      default:      in_data_c = 8'h00;
    endcase
  end

  assign bus.IN_DATA   = in_data_c;
  assign bus.INTERRUPT = interrupt_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed self-checking bench for intr_arbiter with hand-computed expectations.
module tb_intr_arbiter;
  import intr_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] IRQ_IN;
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] rdata;

  intr_arbiter_if bus ();

  intr_arbiter #(.NUM_SRC(8), .HOLD_CYC(2), .TIMEOUT_CYC(16)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .IRQ_IN (IRQ_IN),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    tick();
    bus.IO_STRB  = 1'b0;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
    bus.PORT_ID = id;
    #1;
    rdata = bus.IN_DATA;
    bus.PORT_ID = 8'h00;
    chk(tag, rdata, exp);
  endtask

  task automatic chk_int(input string tag, input logic exp);
    chk(tag, 8'(bus.INTERRUPT), 8'(exp));
  endtask

  initial begin
    RST_N        = 1'b0;
    IRQ_IN       = 8'h00;
    bus.PORT_ID  = 8'h00;
    bus.OUT_PORT = 8'h00;
    bus.IO_STRB  = 1'b0;
    repeat (3) tick();
    chk_int("rst_int", 1'b0);
    chk_rd("rst_mask", INTR_MASK_ID, 8'h00);
    chk_rd("rst_stat", INTR_STAT_ID, 8'h00);
    chk_rd("rst_vec", INTR_VEC_ID, 8'h00);
    chk_rd("rst_other", 8'h12, 8'h00);
    RST_N = 1'b1;
    repeat (4) tick();

    // Single source 3 with everything enabled
    wr(INTR_MASK_ID, 8'hFF);
    chk_rd("mask_ff", INTR_MASK_ID, 8'hFF);
    IRQ_IN = 8'h08;
    tick(); tick();
    chk_rd("t1_stat_c2", INTR_STAT_ID, 8'h00);
    tick();
    chk_rd("t1_stat_c3", INTR_STAT_ID, 8'h08);
    chk_int("t1_int_c3", 1'b0);
    tick();
    chk_int("t1_int_h1", 1'b1);
    chk_rd("t1_vec", INTR_VEC_ID, 8'h03);
    tick();
    chk_int("t1_int_h2", 1'b1);
    tick();
    chk_int("t1_int_wait", 1'b0);
    tick();
    chk_int("t1_int_wait2", 1'b0);
    IRQ_IN = 8'h00;
    wr(INTR_ACK_ID, 8'h08);
    chk_rd("t1_stat_ack", INTR_STAT_ID, 8'h00);
    tick();
    chk_int("t1_int_idle", 1'b0);

    // Simultaneous sources 5 and 1: priority, then ack of one re-asserts the other
    IRQ_IN = 8'h22;
    repeat (3) tick();
    chk_rd("t2_stat", INTR_STAT_ID, 8'h22);
    tick();
    chk_int("t2_int_h1", 1'b1);
    chk_rd("t2_vec1", INTR_VEC_ID, 8'h01);
    tick();
    tick();
    chk_int("t2_int_wait", 1'b0);
    IRQ_IN = 8'h00;
    wr(INTR_ACK_ID, 8'h02);
    chk_int("t2_int_gap", 1'b0);
    chk_rd("t2_stat_left", INTR_STAT_ID, 8'h20);
    tick();
    chk_int("t2_int_re", 1'b1);
    chk_rd("t2_vec5", INTR_VEC_ID, 8'h05);
    tick(); tick();
    chk_int("t2_int_wait2", 1'b0);
    wr(INTR_ACK_ID, 8'h20);
    tick();
    chk_int("t2_int_done", 1'b0);
    chk_rd("t2_stat_done", INTR_STAT_ID, 8'h00);

    // Masked source 2 is retained and fires once unmasked
    wr(INTR_MASK_ID, 8'h00);
    IRQ_IN = 8'h04;
    repeat (3) tick();
    IRQ_IN = 8'h00;
    chk_rd("t3_stat_masked", INTR_STAT_ID, 8'h00);
    tick(); tick();
    chk_int("t3_int_masked", 1'b0);
    wr(INTR_MASK_ID, 8'h04);
    chk_int("t3_int_unmask0", 1'b0);
    chk_rd("t3_stat_unmask", INTR_STAT_ID, 8'h04);
    tick();
    chk_int("t3_int_unmask1", 1'b1);
    chk_rd("t3_vec", INTR_VEC_ID, 8'h02);
    // Mask cleared mid-ASSERT: sequence and vector unchanged
    wr(INTR_MASK_ID, 8'h00);
    chk_int("t3_int_maskoff", 1'b1);
    chk_rd("t3_vec_hold", INTR_VEC_ID, 8'h02);
    tick();
    chk_int("t3_int_wait", 1'b0);
    chk_rd("t3_vec_wait", INTR_VEC_ID, 8'h02);
    wr(INTR_ACK_ID, 8'h04);
    wr(INTR_MASK_ID, 8'hFF);
    chk_rd("t3_stat_done", INTR_STAT_ID, 8'h00);

    // Ack of source 0 colliding with a new edge on source 0: set wins
    IRQ_IN = 8'h01;
    repeat (3) tick();
    chk_rd("t4_stat", INTR_STAT_ID, 8'h01);
    tick();
    chk_int("t4_int_h1", 1'b1);
    tick(); tick();
    chk_int("t4_int_wait", 1'b0);
    IRQ_IN = 8'h00;
    repeat (3) tick();
    IRQ_IN = 8'h01;
    tick(); tick();
    wr(INTR_ACK_ID, 8'h01);
    chk_int("t4_int_gap", 1'b0);
    chk_rd("t4_stat_kept", INTR_STAT_ID, 8'h01);
    tick();
    chk_int("t4_int_re", 1'b1);
    chk_rd("t4_vec", INTR_VEC_ID, 8'h00);
    tick(); tick();
    chk_int("t4_int_wait2", 1'b0);
    IRQ_IN = 8'h00;
    wr(INTR_ACK_ID, 8'h01);
    chk_rd("t4_stat_done", INTR_STAT_ID, 8'h00);

    // Reset during ASSERT, with source 6 held high across release
    IRQ_IN = 8'h40;
    repeat (3) tick();
    tick();
    chk_int("t5_int_pre", 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk_int("t5_int_async", 1'b0);
    chk_rd("t5_mask_rst", INTR_MASK_ID, 8'h00);
    chk_rd("t5_vec_rst", INTR_VEC_ID, 8'h00);
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (6) tick();
    chk_int("t5_int_rel", 1'b0);
    wr(INTR_MASK_ID, 8'hFF);
    chk_rd("t5_stat_rel", INTR_STAT_ID, 8'h00);
    tick();
    chk_int("t5_int_rel2", 1'b0);
    IRQ_IN = 8'h00;

    // No acknowledge: timeout re-assert when enabled, otherwise wait forever
    IRQ_IN = 8'h10;
    repeat (3) tick();
    chk_rd("t6_stat", INTR_STAT_ID, 8'h10);
    tick();
    chk_int("t6_int_h1", 1'b1);
    tick(); tick();
    chk_int("t6_int_wait", 1'b0);
`ifdef INTR_TIMEOUT_EN
    repeat (15) tick();
    chk_int("t6_int_to15", 1'b0);
    tick();
    chk_int("t6_int_to_idle", 1'b0);
    tick();
    chk_int("t6_int_reassert", 1'b1);
    chk_rd("t6_vec", INTR_VEC_ID, 8'h04);
    tick(); tick();
    chk_int("t6_int_wait2", 1'b0);
`else
    repeat (40) tick();
    chk_int("t6_int_noto", 1'b0);
    chk_rd("t6_stat_kept", INTR_STAT_ID, 8'h10);
`endif
    IRQ_IN = 8'h00;
    wr(INTR_ACK_ID, 8'h10);
    tick();
    chk_int("t6_int_done", 1'b0);
    chk_rd("t6_stat_done", INTR_STAT_ID, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
